divider_issue_ctrl: RTL and testbench
=====================================

// Module: divider_issue_ctrl
// PURPOSE
//  Sits directly upstream/downstream of divider_pipe and wraps its fixed-latency datapath.
//  Accepts divide requests on a valid/ready port and drives the divider operands.
//  Tracks in-flight ops with a valid/tag shift line; captures results into a result FIFO.
//  Credit scheme: a result is never dropped, because divider_pipe cannot stall.
// PARAMETERS
//  WIDTH      5   divisor/quotient/remainder width; dividend is 2*WIDTH
//  LATENCY    5   divider_pipe operand-to-result cycles (>=1)
//  RES_DEPTH  8   result FIFO entries (>=1); full rate needs RES_DEPTH >= LATENCY+1
//  TAG_W      4   request tag width, echoed with result
// PORTS
//  clk                  in   1        clock
//  reset                in   1        asynchronous, active-high
//  in_valid             in   1        request valid
//  in_ready             out  1        request accepted when in_valid&in_ready at posedge
//  in_dividend          in   2*WIDTH  dividend
//  in_divisor           in   WIDTH    divisor
//  in_tag               in   TAG_W    request tag
//  div_dividend         out  2*WIDTH  to divider_pipe.dividend (registered)
//  div_divisor          out  WIDTH    to divider_pipe.divisor (registered)
//  div_quotient         in   WIDTH    from divider_pipe
//  div_remainder        in   WIDTH    from divider_pipe
//  div_overflow         in   1        from divider_pipe
//  div_error_div_zero   in   1        from divider_pipe.error_divide_by_zero
//  out_valid            out  1        result FIFO non-empty
//  out_ready            in   1        pop when out_valid&out_ready at posedge
//  out_quotient/out_remainder out WIDTH  head result
//  out_overflow/out_div_zero  out 1      head flags
//  out_tag              out  TAG_W    tag of head result
//  busy                 out  1        any op in flight or FIFO non-empty
// BEHAVIOUR
//  - Reset (async): shift line valids=0; inflight_cnt=0; FIFO empty; div_* = 0; all out_* = 0.
//  - Mid-operation reset: all in-flight and queued results discarded; no stale result after release.
//  - in_ready = (inflight_cnt + fifo_cnt) < RES_DEPTH, from registered counts only.
//  - No combinational path out_ready->in_ready; a pop frees its credit on the next cycle.
//  - Accept at edge N: div_dividend/div_divisor load the operands; line[0] <= {1,tag}.
//  - No accept: div_* HOLD last issued values; line[0].valid <= 0.
//  - Shift line is LATENCY deep; line[LATENCY-1].valid marks div_* inputs belonging to a request.
//  - At edge N+LATENCY, result+tag are written to the FIFO; out_valid is high after that edge.
//  - Accept-to-out_valid latency is exactly LATENCY cycles.
//  - inflight_cnt: +1 on accept, -1 on line-out valid; both in one cycle -> unchanged.
//  - fifo_cnt: +1 on write, -1 on pop; both in one cycle -> unchanged. Simultaneous push/pop on a full FIFO is legal.
//  - Write to a full FIFO is impossible by credit; assertion fires if attempted.
//  - FIFO pointers are log2(RES_DEPTH) bits and wrap modulo RES_DEPTH (non-power-of-2 supported).
//  - Divider flags are passed through unmodified; q/r are don't-care when overflow/div_zero is set.
//  - Results leave in strict acceptance order.
//  - Full throughput: 1 accept/cycle while out_ready=1 and RES_DEPTH >= LATENCY+1.
//  - busy = |line valids | (fifo_cnt!=0).
// STRUCTURE
//  - divider_pkg: DIV_WIDTH default constant;
//    typedef div_result_t {quotient, remainder, overflow, div_zero, tag}; clog2 helper for pointer widths.
//  - Sub-module div_result_fifo: sync FIFO of div_result_t, RES_DEPTH deep, count output.
//  - Top holds the credit counter, tag/valid shift line and operand registers.
//  - Bench instantiates divider_issue_ctrl + divider_pipe; scoreboard checks against a behavioural model.
// TESTING
//  1. 100/7, tag 3, out_ready=1 -> out_valid exactly 5 cycles after accept; q=14 r=2 ovf=0 dz=0 tag=3.
//  2. 50/0, tag 1 -> out_div_zero=1, out_tag=1; next request 31/31 -> q=1 r=0 dz=0.
//  3. 1000/3 (q=333 > 31) -> out_overflow=1; 93/3 -> q=31 r=0 ovf=0.
//  4. out_ready=0, in_valid held for 12 cycles -> exactly 8 accepted, then in_ready=0.
//     Release out_ready -> 8 results in tag order, none lost/duplicated; in_ready rises the cycle after the first pop.
//  5. out_ready=1, 32 back-to-back requests -> in_ready never drops; results 1/cycle in order; busy falls after last pop.
//  6. 3 ops in flight + 2 in FIFO, assert reset 1 cycle -> out_valid=0, busy=0, div_*=0.
//     No result appears for 2*LATENCY cycles after release.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and helpers for the divider issue controller and its result FIFO.
package divider_pkg;

  localparam int unsigned DIV_WIDTH = 5;
  localparam int unsigned DIV_TAG_W = 4;

  typedef struct packed {
    logic [DIV_WIDTH-1:0] quotient;
    logic [DIV_WIDTH-1:0] remainder;
    logic                 overflow;
    logic                 div_zero;
    logic [DIV_TAG_W-1:0] tag;
  } div_result_t;

  // Never returns zero so a 1-deep structure still gets a legal 1-bit pointer.
  function automatic int unsigned clog2(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/div_result_fifo.sv
// Synchronous result FIFO; pointers wrap modulo DEPTH so any depth >= 1 works.
module div_result_fifo
  import divider_pkg::*;
#(
  parameter type         T     = div_result_t,
  parameter int unsigned DEPTH = 8
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_push,
  input  T                            i_wdata,
  input  logic                        i_pop,
  output T                            o_rdata,
  output logic [clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned PtrW = clog2(DEPTH);
  localparam int unsigned CntW = clog2(DEPTH + 1);

  T                r_mem [DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;
  logic            w_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign w_pop = i_pop && (r_count != '0);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Credit accounting upstream must make this unreachable.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      assert (!(i_push && !w_pop && (r_count == CntW'(DEPTH))))
        else $error("div_result_fifo: push while full");
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/divider_issue_ctrl.sv
// Issue/credit controller around a fixed-latency, non-stallable divider pipe.
// Results are queued in a FIFO that is pre-reserved at accept time, so none is ever dropped.
module divider_issue_ctrl
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH     = DIV_WIDTH,
  parameter int unsigned LATENCY   = 5,
  parameter int unsigned RES_DEPTH = 8,
  parameter int unsigned TAG_W     = DIV_TAG_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   in_dividend,
  input  logic [WIDTH-1:0]     in_divisor,
  input  logic [TAG_W-1:0]     in_tag,
  output logic [2*WIDTH-1:0]   div_dividend,
  output logic [WIDTH-1:0]     div_divisor,
  input  logic [WIDTH-1:0]     div_quotient,
  input  logic [WIDTH-1:0]     div_remainder,
  input  logic                 div_overflow,
  input  logic                 div_error_div_zero,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_quotient,
  output logic [WIDTH-1:0]     out_remainder,
  output logic                 out_overflow,
  output logic                 out_div_zero,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 busy
);

  localparam int unsigned CntW = clog2(RES_DEPTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             overflow;
    logic             div_zero;
    logic [TAG_W-1:0] tag;
  } res_t;

  logic [LATENCY-1:0] r_line_valid;
  logic [TAG_W-1:0]   r_line_tag [LATENCY];
  logic [CntW-1:0]    r_inflight_cnt;
  logic [CntW-1:0]    w_fifo_cnt;
  logic [CntW:0]      w_credit_used;
  logic               w_accept;
  logic               w_line_out;
  logic               w_pop;
  res_t               w_push_data;
  res_t               w_head;

  // Registered counts only, so a pop returns its credit one cycle later.
  assign w_credit_used = {1'b0, r_inflight_cnt} + {1'b0, w_fifo_cnt};
  assign in_ready      = w_credit_used < (CntW + 1)'(RES_DEPTH);
  assign w_accept      = in_valid && in_ready;
  assign w_line_out    = r_line_valid[LATENCY-1];
  assign w_pop         = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_line_valid   <= '0;
      r_inflight_cnt <= '0;
      div_dividend   <= '0;
      div_divisor    <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) r_line_tag[i] <= '0;
    end else begin
      r_line_valid[0] <= w_accept;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        r_line_valid[i] <= r_line_valid[i-1];
        r_line_tag[i]   <= r_line_tag[i-1];
      end
      if (w_accept) begin
        r_line_tag[0] <= in_tag;
        div_dividend  <= in_dividend;
        div_divisor   <= in_divisor;
      end
      case ({w_accept, w_line_out})
        2'b10:   r_inflight_cnt <= r_inflight_cnt + CntW'(1);
        2'b01:   r_inflight_cnt <= r_inflight_cnt - CntW'(1);
        default: r_inflight_cnt <= r_inflight_cnt;
      endcase
    end
  end

  always_comb begin
    w_push_data           = '0;
    w_push_data.quotient  = div_quotient;
    w_push_data.remainder = div_remainder;
    w_push_data.overflow  = div_overflow;
    w_push_data.div_zero  = div_error_div_zero;
    w_push_data.tag       = r_line_tag[LATENCY-1];
  end

  div_result_fifo #(
    .T     (res_t),
    .DEPTH (RES_DEPTH)
  ) u_result_fifo (
    .i_clk   (clk),
    .i_reset (reset),
    .i_push  (w_line_out),
    .i_wdata (w_push_data),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_fifo_cnt)
  );

  assign out_valid     = (w_fifo_cnt != '0);
  assign out_quotient  = out_valid ? w_head.quotient  : '0;
  assign out_remainder = out_valid ? w_head.remainder : '0;
  assign out_overflow  = out_valid ? w_head.overflow  : 1'b0;
  assign out_div_zero  = out_valid ? w_head.div_zero  : 1'b0;
  assign out_tag       = out_valid ? w_head.tag       : '0;
  assign busy          = (|r_line_valid) || out_valid;

endmodule

// File: tb/tb_divider_issue_ctrl.sv
// Bench: controller plus a fixed-latency divider stand-in, checked against a queue-based model.
module tb_divider_issue_ctrl;

  localparam int unsigned WIDTH     = 5;
  localparam int unsigned LATENCY   = 5;
  localparam int unsigned RES_DEPTH = 8;
  localparam int unsigned TAG_W     = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [2*WIDTH-1:0] in_dividend = '0;
  logic [WIDTH-1:0]   in_divisor = '0;
  logic [TAG_W-1:0]   in_tag = '0;
  logic [2*WIDTH-1:0] div_dividend;
  logic [WIDTH-1:0]   div_divisor;
  logic [WIDTH-1:0]   div_quotient;
  logic [WIDTH-1:0]   div_remainder;
  logic               div_overflow;
  logic               div_error_div_zero;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [WIDTH-1:0]   out_quotient;
  logic [WIDTH-1:0]   out_remainder;
  logic               out_overflow;
  logic               out_div_zero;
  logic [TAG_W-1:0]   out_tag;
  logic               busy;

  always #5 clk = ~clk;

  divider_issue_ctrl #(
    .WIDTH     (WIDTH),
    .LATENCY   (LATENCY),
    .RES_DEPTH (RES_DEPTH),
    .TAG_W     (TAG_W)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_dividend        (in_dividend),
    .in_divisor         (in_divisor),
    .in_tag             (in_tag),
    .div_dividend       (div_dividend),
    .div_divisor        (div_divisor),
    .div_quotient       (div_quotient),
    .div_remainder      (div_remainder),
    .div_overflow       (div_overflow),
    .div_error_div_zero (div_error_div_zero),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_quotient       (out_quotient),
    .out_remainder      (out_remainder),
    .out_overflow       (out_overflow),
    .out_div_zero       (out_div_zero),
    .out_tag            (out_tag),
    .busy               (busy)
  );

  // Divider stand-in: result for operands issued at edge N is presented before edge N+LATENCY.
  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             o;
    logic             z;
  } dres_t;

  function automatic dres_t divide(input logic [2*WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    dres_t res;
    int    qq;
    res = '0;
    if (b == '0) begin
      res.z = 1'b1;
      res.q = '1;
      res.r = '1;
    end else begin
      qq    = int'(a) / int'(b);
      res.o = (qq > 31);
      res.q = qq[WIDTH-1:0];
      res.r = WIDTH'(int'(a) % int'(b));
    end
    return res;
  endfunction

  dres_t pipe [LATENCY-1];

  always @(posedge clk) begin
    pipe[0] <= divide(div_dividend, div_divisor);
    for (int i = 1; i < LATENCY - 1; i++) pipe[i] <= pipe[i-1];
  end

  assign div_quotient       = pipe[LATENCY-2].q;
  assign div_remainder      = pipe[LATENCY-2].r;
  assign div_overflow       = pipe[LATENCY-2].o;
  assign div_error_div_zero = pipe[LATENCY-2].z;

  // Reference model: every accepted op owns one credit until popped, and becomes
  // visible LATENCY edges after its accept edge, in acceptance order.
  typedef struct {
    int q;
    int r;
    bit ovf;
    bit dz;
    int tag;
    int acc;
  } exp_t;

  exp_t           mq[$];
  int             cyc = 0;
  int             vectors = 0;
  int             miscompares = 0;
  int             dut_acc = 0;
  int             ready_low = 0;
  int             last_dvd = 0;
  int             last_dvs = 0;

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", nm, obs, expv);
    end
  endtask

  task automatic cycle(input bit v, input int dvd, input int dvs, input int tag, input bit ordy);
    bit   exp_ready;
    bit   exp_valid;
    exp_t e;
    in_valid    = v;
    in_dividend = (2*WIDTH)'(dvd);
    in_divisor  = WIDTH'(dvs);
    in_tag      = TAG_W'(tag);
    out_ready   = ordy;
    #1;
    exp_ready = (mq.size() < RES_DEPTH);
    exp_valid = 1'b0;
    if (mq.size() != 0) exp_valid = ((cyc - mq[0].acc) >= int'(LATENCY));
    chk("in_ready", in_ready, exp_ready);
    chk("out_valid", out_valid, exp_valid);
    chk("busy", busy, mq.size() != 0);
    chk("div_dividend", div_dividend, last_dvd);
    chk("div_divisor", div_divisor, last_dvs);
    if (exp_valid) begin
      chk("out_tag", out_tag, mq[0].tag);
      chk("out_overflow", out_overflow, mq[0].ovf);
      chk("out_div_zero", out_div_zero, mq[0].dz);
      if (!mq[0].ovf && !mq[0].dz) begin
        chk("out_quotient", out_quotient, mq[0].q);
        chk("out_remainder", out_remainder, mq[0].r);
      end
    end
    if (v && in_ready) dut_acc++;
    if (!in_ready) ready_low++;
    if (ordy && exp_valid) e = mq.pop_front();
    if (v && exp_ready) begin
      e.tag = tag % 16;
      e.dz  = (dvs == 0);
      e.q   = e.dz ? 0 : dvd / dvs;
      e.r   = e.dz ? 0 : dvd % dvs;
      e.ovf = !e.dz && (e.q > 31);
      e.acc = cyc + 1;
      mq.push_back(e);
      last_dvd = dvd;
      last_dvs = dvs;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 1, 0, ordy);
  endtask

  task automatic head_is(input string nm, input int q, input int r, input bit ovf, input bit dz,
                         input int tag, input bit chk_qr);
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_tag"}, out_tag, tag);
    chk({nm, "_ovf"}, out_overflow, ovf);
    chk({nm, "_dz"}, out_div_zero, dz);
    if (chk_qr) begin
      chk({nm, "_q"}, out_quotient, q);
      chk({nm, "_r"}, out_remainder, r);
    end
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_div_dividend", div_dividend, 0);
    chk("rst_div_divisor", div_divisor, 0);
    chk("rst_out_q", out_quotient, 0);
    chk("rst_out_r", out_remainder, 0);
    chk("rst_out_ovf", out_overflow, 0);
    chk("rst_out_dz", out_div_zero, 0);
    chk("rst_out_tag", out_tag, 0);
    @(negedge clk);
    reset = 1'b0;

    // 1: basic divide, exact latency
    cycle(1'b1, 100, 7, 3, 1'b1);
    idle(5, 1'b0);
    head_is("t1", 14, 2, 0, 0, 3, 1);
    idle(2, 1'b1);

    // 2: divide by zero, then a normal op
    cycle(1'b1, 50, 0, 1, 1'b0);
    cycle(1'b1, 31, 31, 2, 1'b0);
    idle(5, 1'b0);
    head_is("t2a", 0, 0, 0, 1, 1, 0);
    idle(1, 1'b1);
    head_is("t2b", 1, 0, 0, 0, 2, 1);
    idle(2, 1'b1);

    // 3: quotient overflow, then the largest in-range quotient
    cycle(1'b1, 1000, 3, 5, 1'b0);
    cycle(1'b1, 93, 3, 6, 1'b0);
    idle(5, 1'b0);
    head_is("t3a", 0, 0, 1, 0, 5, 0);
    idle(1, 1'b1);
    head_is("t3b", 31, 0, 0, 0, 6, 1);
    idle(2, 1'b1);

    // 4: backpressure fills all credits
    dut_acc = 0;
    for (int i = 0; i < 12; i++) cycle(1'b1, 7 * i + 5, 3, i, 1'b0);
    chk("t4_accepts", dut_acc, 8);
    chk("t4_in_ready_low", in_ready, 0);
    idle(14, 1'b1);
    chk("t4_drained_busy", busy, 0);

    // 5: back-to-back stream at full rate
    dut_acc   = 0;
    ready_low = 0;
    for (int i = 0; i < 32; i++)
      cycle(1'b1, int'($urandom_range(0, 1023)), int'($urandom_range(1, 31)), i, 1'b1);
    chk("t5_accepts", dut_acc, 32);
    chk("t5_ready_drops", ready_low, 0);
    idle(LATENCY + 2, 1'b1);
    chk("t5_busy_after", busy, 0);

    // 6: reset with work in flight and queued
    cycle(1'b1, 200, 9, 10, 1'b0);
    cycle(1'b1, 201, 9, 11, 1'b0);
    idle(5, 1'b0);
    cycle(1'b1, 300, 7, 12, 1'b0);
    cycle(1'b1, 301, 7, 13, 1'b0);
    cycle(1'b1, 302, 7, 14, 1'b0);
    chk("t6_pre_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_div_dividend", div_dividend, 0);
    chk("t6_div_divisor", div_divisor, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mq.delete();
    last_dvd = 0;
    last_dvs = 0;
    idle(2 * LATENCY, 1'b1);

    // Randomized traffic with random backpressure and occasional zero divisors
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 1023)),
            ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 31)),
            i, $urandom_range(0, 3) != 0);
    end
    idle(RES_DEPTH + LATENCY + 2, 1'b1);
    chk("final_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
